// File: rtl/run_ctrl.sv
// run_ctrl: run sequencer for the 9-bit-instruction / 8-bit-datapath core.
// Holds the core in reset, releases it, gates it with core_en, and stops on
// the halt instruction or when the RUN-cycle budget expires.
// Optional single-step support is compiled in with `define RUN_CTRL_STEP_EN.
module run_ctrl #(
    parameter int                   PC_W      = 6,
    parameter int                   INSTR_W   = 9,
    parameter logic [INSTR_W-1:0]   HALT_CODE = 9'h1FF,
    parameter int                   INIT_CYC  = 2,
    parameter int                   MAX_CYC   = 4096,
    parameter int                   CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [PC_W-1:0]    pc,
`ifdef RUN_CTRL_STEP_EN
    input  logic               step_mode,
    input  logic               step,
`endif
    output logic               core_reset,
    output logic               core_en,
    output logic               busy,
    output logic               done,
    output logic               timed_out,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [PC_W-1:0]    halt_pc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Counter wide enough to count 0..INIT_CYC-1 (INIT_CYC is at least 1).
    localparam int                INIT_W    = $clog2(INIT_CYC + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYC - 1);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_CYC);

    logic [1:0]        state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic [PC_W-1:0]   halt_pc_q, halt_pc_d;
    logic              timed_out_q, timed_out_d;
    logic              core_reset_q, core_reset_d;
    logic              core_en_q, core_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  cnt_inc;
    logic              run_en;
    logic              step_ok;

`ifdef RUN_CTRL_STEP_EN
    logic step_q;

    // Step history for rising-edge detection of the step input.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    // In step mode the core advances once per 0->1 step transition.
    always_comb begin
        step_ok = 1'b1;
        if (step_mode) begin
            step_ok = step & ~step_q;
        end
    end
`else
    // Without stepping support the core free-runs in RUN.
    always_comb begin
        step_ok = 1'b1;
    end
`endif

    // Next-state, counters and the registered output decode.
    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        cycle_count_d = cycle_count_q;
        halt_pc_d     = halt_pc_q;
        timed_out_d   = timed_out_q;

        // Saturating increment: the count sticks at all-ones.
        cnt_inc = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;
        // Only cycles where the core actually advanced are counted/checked.
        run_en  = (state_q == S_RUN) && core_en_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d       = S_INIT;
                    init_cnt_d    = '0;
                    cycle_count_d = '0;
                    timed_out_d   = 1'b0;
                    halt_pc_d     = '0;
                end
            end
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = S_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (run_en) begin
                    cycle_count_d = cnt_inc;
                    // Halt takes priority over budget expiry on the same cycle.
                    if (instruction == HALT_CODE) begin
                        state_d   = S_DONE;
                        halt_pc_d = pc;
                    end else if ((MAX_CYC != 0) && (cnt_inc == MAX_CNT)) begin
                        state_d     = S_DONE;
                        timed_out_d = 1'b1;
                        halt_pc_d   = pc;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        core_reset_d = (state_d == S_IDLE) || (state_d == S_INIT);
        busy_d       = (state_d == S_INIT) || (state_d == S_RUN);
        done_d       = (state_d == S_DONE);
        core_en_d    = (state_d == S_RUN) && step_ok;
    end

    // State and output registers; reset returns everything to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            init_cnt_q    <= '0;
            cycle_count_q <= '0;
            halt_pc_q     <= '0;
            timed_out_q   <= 1'b0;
            core_reset_q  <= 1'b1;
            core_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            cycle_count_q <= cycle_count_d;
            halt_pc_q     <= halt_pc_d;
            timed_out_q   <= timed_out_d;
            core_reset_q  <= core_reset_d;
            core_en_q     <= core_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign core_reset  = core_reset_q;
    assign core_en     = core_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timed_out   = timed_out_q;
    assign cycle_count = cycle_count_q;
    assign halt_pc     = halt_pc_q;

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Top-level run sequencer for the 9-bit-instruction, 8-bit-datapath core.
- Sequences one program execution: holds the core in reset, releases it, and gates execution with a clock-enable.
- Watches the fetched instruction and PC, detects the halt instruction or a cycle-budget timeout, and reports done, status, cycle count and halt PC.
- Sits between the bench/host start/done interface and the core's reset/enable inputs.

Parameters:
- PC_W, 6, program counter width.
- INSTR_W, 9, instruction width.
- HALT_CODE, 9'h1FF, instruction encoding that ends the program.
- INIT_CYC, 2, cycles core_reset is held high after start (must be ≥1).
- MAX_CYC, 4096, RUN-cycle budget before timeout; 0 disables the timeout.
- CNT_W, 16, cycle counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  start request; sampled only in IDLE or DONE.
- instruction  in  INSTR_W  instruction currently fetched by the core.
- pc  in  PC_W  current core PC.
- core_reset  out  1  reset to the core (program counter, register file).
- core_en  out  1  core advance enable; the core updates state only when this is 1.
- busy  out  1  high in INIT and RUN.
- done  out  1  high in DONE.
- timed_out  out  1  high in DONE when the run ended by budget rather than halt.
- cycle_count  out  CNT_W  enabled RUN cycles in the current or last run.
- halt_pc  out  PC_W  pc latched when the run ended.

Behaviour:
- All outputs are registered and come straight from state or registers; no combinational input-to-output paths.
- Reset (sync, any state, including mid-run):
  - state=IDLE, core_reset=1, core_en=0, busy=0, done=0, timed_out=0, cycle_count=0, halt_pc=0.
  - Reset wins over every other event in the same cycle.
- States: IDLE, INIT, RUN, DONE.
- IDLE:
  - core_reset=1, core_en=0.
  - start=1 → INIT next cycle; also clears cycle_count, timed_out, halt_pc.
- INIT:
  - core_reset=1, core_en=0, busy=1.
  - An internal counter holds INIT for exactly INIT_CYC cycles, then → RUN.
- RUN:
  - core_reset=0, core_en=1, busy=1.
  - Each enabled cycle: cycle_count += 1, saturating at all-ones, no wrap.
  - If instruction==HALT_CODE on an enabled cycle → DONE; halt_pc=pc; the halt cycle is counted.
  - Else if MAX_CYC≠0 and the post-increment count == MAX_CYC → DONE; timed_out=1; halt_pc=pc.
  - Halt and budget expiry in the same cycle: halt wins, timed_out=0.
- DONE:
  - core_reset=0 so the core state stays inspectable; core_en=0; done=1.
  - cycle_count, halt_pc and timed_out hold.
  - start=1 → INIT (restart); done falls the next cycle and the counters clear.
- start is ignored in INIT and RUN.
- Timing from start sampled high at edge 0:
  - busy=1 and core_reset=1 for cycles 1..INIT_CYC.
  - core_en=1 first in cycle INIT_CYC+1.
  - done=1 the cycle after the halt cycle.
- An unknown or illegal state encoding recovers to IDLE.

Optional Feature:
- Macro RUN_CTRL_STEP_EN.
- When defined:
  - Adds ports step_mode in 1 and step in 1.
  - In RUN with step_mode=1, core_en=1 for exactly one cycle per 0→1 transition of step. Rising-edge detection uses a registered step, so core_en goes high the cycle after the transition.
  - cycle_count, the halt check and the budget check advance only on enabled cycles.
  - step_mode=0 gives free-run.
  - Reset clears the step history register.
- When undefined: the ports are absent and core_en=1 on every RUN cycle.

Test Plan:
- Reset, then idle 5 cycles → core_reset=1, core_en=0, done=0, cycle_count=0 throughout.
- INIT_CYC=2; pulse start; halt instruction presented on the 10th RUN cycle at pc=6'h09 → core_reset high exactly 2 cycles, done=1 one cycle after the halt cycle, cycle_count=10, halt_pc=9, timed_out=0.
- MAX_CYC=8, instruction never HALT_CODE → DONE after 8 RUN cycles, timed_out=1, cycle_count=8; MAX_CYC=0 with no halt for 100 cycles → still RUN.
- Halt on the same cycle the budget hits 8 → timed_out=0, cycle_count=8; start pulses during RUN are ignored.
- Assert reset on the 4th RUN cycle → next cycle IDLE, core_reset=1, cycle_count=0; then start in DONE → restart with done cleared and cycle_count=0.
- With RUN_CTRL_STEP_EN, step_mode=1, three step pulses spaced 4 cycles apart → exactly 3 single-cycle core_en pulses, cycle_count=3.
